// File: rtl/rob_dispatch_ctrl.sv
// Dispatch controller for the Decode->ROB register: ROB credit tracking,
// halt/flush generation and mispredict flush/drain sequencing.
module rob_dispatch_ctrl #(
  parameter int IPC          = 1,
  parameter int ROB_DEPTH    = 32,
  parameter int CNT_WIDTH    = 6,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IPC-1:0]               valid_ROB,
  input  logic [$clog2(IPC+1)-1:0]     commit_count,
  input  logic                         rs_full,
  input  logic                         mispredict,
  output logic                         halt,
  output logic                         flush,
  output logic                         ready,
  output logic [CNT_WIDTH-1:0]         credits,
  output logic [1:0]                   state,
  output logic                         err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_WIDTH:0]   DEPTH_W  = (CNT_WIDTH+1)'(ROB_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CRED_MAX = CNT_WIDTH'(ROB_DEPTH);
  localparam logic [DW-1:0]        DRAIN_LD = DW'(DRAIN_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] credits_q, credits_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH:0]   need, sum;

  always_comb begin
    need = '0;
    for (int i = 0; i < IPC; i++) need = need + (CNT_WIDTH+1)'(valid_ROB[i]);
  end

  assign halt  = (state_q != S_IDLE) | rs_full | ({1'b0, credits_q} < need);
  assign flush = (state_q == S_FLUSH);
  assign ready = (state_q == S_IDLE) & ~halt;

  // Extra bit catches commit pushing the count past the ROB size.
  assign sum = {1'b0, credits_q} - (halt ? '0 : need) + (CNT_WIDTH+1)'(commit_count);

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    drain_d   = drain_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (sum > DEPTH_W) begin
          credits_d = CRED_MAX;
          err_d     = 1'b1;
        end else begin
          credits_d = sum[CNT_WIDTH-1:0];
        end
        if (mispredict) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d   = S_DRAIN;
        credits_d = CRED_MAX;
        drain_d   = DRAIN_LD;
      end
      S_DRAIN: begin
        if (mispredict)        state_d = S_FLUSH;
        else if (drain_q == '0) state_d = S_IDLE;
        else                   drain_d = drain_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      credits_q <= CRED_MAX;
      drain_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
    end
  end

  assign credits = credits_q;
  assign state   = state_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Randomized bench for rob_dispatch_ctrl against a countdown-based recovery model.
module tb_rob_dispatch_ctrl;
  localparam int IPC = 2, RD = 8, CW = 4, DC = 3;

  logic           clk = 1'b0, rst = 1'b1;
  logic [IPC-1:0] valid_ROB = '0;
  logic [1:0]     commit_count = '0;
  logic           rs_full = 1'b0, mispredict = 1'b0;
  logic           halt, flush, ready, err;
  logic [CW-1:0]  credits;
  logic [1:0]     state;

  int n_chk = 0, n_err = 0;

  // Model: recov counts remaining halted recovery cycles; DC+1 marks the flush cycle.
  int m_cred, m_recov;
  bit m_err;

  rob_dispatch_ctrl #(.IPC(IPC), .ROB_DEPTH(RD), .CNT_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .valid_ROB(valid_ROB), .commit_count(commit_count),
    .rs_full(rs_full), .mispredict(mispredict), .halt(halt), .flush(flush),
    .ready(ready), .credits(credits), .state(state), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_need();
    int n = 0;
    for (int i = 0; i < IPC; i++) n += valid_ROB[i];
    return n;
  endfunction

  function automatic int m_state();
    if (m_recov == 0) return 0;
    if (m_recov == DC + 1) return 1;
    return 2;
  endfunction

  function automatic bit m_halt();
    return (m_state() != 0) || rs_full || (m_cred < m_need());
  endfunction

  task automatic check_outputs();
    chk("state",   32'(state),   32'(m_state()));
    chk("credits", 32'(credits), 32'(m_cred));
    chk("halt",    32'(halt),    32'(m_halt()));
    chk("flush",   32'(flush),   32'(m_state() == 1));
    chk("ready",   32'(ready),   32'(m_state() == 0 && !m_halt()));
    chk("err",     32'(err),     32'(m_err));
  endtask

  task automatic model_clock();
    int s;
    if (m_recov == 0) begin
      s = m_cred - (m_halt() ? 0 : m_need()) + int'(commit_count);
      if (s > RD) begin s = RD; m_err = 1'b1; end
      m_cred  = s;
      m_recov = mispredict ? DC + 1 : 0;
    end else if (m_recov == DC + 1) begin
      m_cred  = RD;
      m_recov = DC;
    end else begin
      m_recov = mispredict ? DC + 1 : m_recov - 1;
    end
  endtask

  task automatic step(input logic [IPC-1:0] v, input logic [1:0] cc,
                      input logic rf, input logic mp);
    @(negedge clk);
    valid_ROB = v; commit_count = cc; rs_full = rf; mispredict = mp;
    #1;
    check_outputs();
    @(posedge clk);
    model_clock();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid_ROB = '0; commit_count = '0; rs_full = 1'b0; mispredict = 1'b0;
    m_cred = RD; m_recov = 0; m_err = 1'b0;
    #2;
    chk("rst_state",   32'(state),   0);
    chk("rst_credits", 32'(credits), RD);
    chk("rst_halt",    32'(halt),    0);
    chk("rst_flush",   32'(flush),   0);
    chk("rst_ready",   32'(ready),   1);
    chk("rst_err",     32'(err),     0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Drain credits two at a time: 8,6,4,2 (exactly equal), 0, then halted.
    for (int i = 0; i < 6; i++) step(2'b11, 2'd0, 1'b0, 1'b0);
    // Zero credits with need and commit together: halted, credits become 1.
    step(2'b01, 2'd1, 1'b0, 1'b0);
    step(2'b01, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd2, 1'b0, 1'b0);
    // rs_full blocks dispatch but commits still count.
    step(2'b11, 2'd0, 1'b1, 1'b0);
    step(2'b00, 2'd0, 1'b0, 1'b0);
    // Refill to full then overflow.
    for (int i = 0; i < 4; i++) step(2'b00, 2'd2, 1'b0, 1'b0);
    step(2'b00, 2'd0, 1'b0, 1'b0);
    chk("err_sticky", 32'(err), 1);

    // Mispredict, then a second one mid-drain restarting the sequence.
    do_reset();
    step(2'b01, 2'd0, 1'b0, 1'b1);
    step(2'b00, 2'd1, 1'b0, 1'b1);
    step(2'b00, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < DC + 3; i++) step(2'b11, 2'd1, 1'b0, 1'b0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(IPC'($urandom), 2'($urandom_range(0, 2)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));

    // Asynchronous reset in FLUSH and in DRAIN.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      step(2'b11, 2'd0, 1'b0, 1'b1);
      for (int j = 0; j < k * 2; j++) step(2'b00, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("pre_rst_state", 32'(state), 32'(m_state()));
      rst = 1'b1;
      #1;
      chk("async_flush", 32'(flush),   0);
      chk("async_state", 32'(state),   0);
      chk("async_cred",  32'(credits), RD);
      chk("async_halt",  32'(halt),    0);
    end
    do_reset();
    step(2'b01, 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rob_dispatch_ctrl.md
# rob_dispatch_ctrl

Dispatch controller for the Decode→ROB pipeline register. Tracks free ROB entries with a credit counter and generates the `halt` and `flush` controls that the Decode→ROB register and upstream stages consume. Sequences branch-mispredict recovery through a small state machine: a one-cycle flush followed by a timed drain window. Sits between decode, the ROB and the reservation stations.

## Interface

Parameters:

- `IPC`, 1, instructions per cycle (dispatch/commit lanes)
- `ROB_DEPTH`, 32, ROB entries; credit reload value
- `CNT_WIDTH`, 6, credit counter width; must hold 0..ROB_DEPTH
- `DRAIN_CYCLES`, 2, halt cycles after a flush before dispatch resumes (≥1)

Ports (`rst` is asynchronous, active-high; the clock is `clk`):

- `clk` input 1: clock
- `rst` input 1: asynchronous, active-high reset
- `valid_ROB` input IPC: per-lane valid of the Decode→ROB register (R|I|S type valid OR'd per lane)
- `commit_count` input $clog2(IPC+1): ROB entries retired this cycle
- `rs_full` input 1: reservation stations cannot accept
- `mispredict` input 1: branch resolution requests recovery
- `halt` output 1: freeze pipeline registers and dispatch
- `flush` output 1: clear pipeline registers and ROB
- `ready` output 1: controller idle and not halting
- `credits` output CNT_WIDTH: current free-entry count
- `state` output 2: 0 = IDLE, 1 = FLUSH, 2 = DRAIN
- `err` output 1: sticky credit-overflow flag

## Operation

- Reset values:
  - `state` = IDLE, `credits` = ROB_DEPTH, drain counter = 0, `err` = 0.
  - Hence `flush` = 0; `halt` = `rs_full`; `ready` = ~`rs_full`.
- Combinational:
  - `need` = popcount(`valid_ROB`).
  - `halt` = (`state` != IDLE) | `rs_full` | (`credits` < `need`).
  - `flush` = (`state` == FLUSH).
  - `ready` = (`state` == IDLE) & ~`halt`.
- `dispatch` = `halt` ? 0 : `need`. Dispatch is all-or-nothing per cycle; there is no partial dispatch across lanes.
- IDLE credit update each cycle:
  - `credits` ← `credits` − `dispatch` + `commit_count`, computed in CNT_WIDTH+1 bits.
  - If the result exceeds ROB_DEPTH: `credits` ← ROB_DEPTH and `err` ← 1. `err` is cleared only by `rst`.
- FSM:
  - IDLE, `mispredict`=1 → FLUSH. Credit update for that cycle still applies.
  - FLUSH → DRAIN unconditionally after 1 cycle. On entry: `credits` ← ROB_DEPTH, drain counter ← DRAIN_CYCLES−1.
  - DRAIN:
    - Drain counter decrements each cycle; at 0 → IDLE.
    - `mispredict`=1 in DRAIN → FLUSH, which restarts the sequence.
    - `commit_count` is ignored in FLUSH and DRAIN (the ROB is empty).
  - `mispredict` in FLUSH is ignored; the sequence already covers it.
- `rs_full` has no effect on the FSM or credits except through `halt`.

## Timing

- `halt` and `flush` are combinational from registered state, `credits`, `valid_ROB` and `rs_full`, and are valid in the same cycle. The Decode→ROB register samples them at the next `clk` edge.
- Credit effect of a dispatch or commit becomes visible in `credits` one cycle later.
- Mispredict recovery:
  - Cycle N: `mispredict` high.
  - Cycle N+1: `flush`=1, `halt`=1.
  - Cycles N+2 .. N+1+DRAIN_CYCLES: `halt`=1, `flush`=0.
  - Cycle N+2+DRAIN_CYCLES: IDLE, `credits` = ROB_DEPTH.
- Boundary cases:
  - `credits`=0 with `commit_count`>0 and `need`>0 in the same cycle: `halt`=1 (the comparison uses current credits), so `credits` ← `commit_count`. Dispatch resumes the next cycle.
  - `credits`=`need` exactly: no halt; `credits` ← 0 + `commit_count`.
  - `rst` asserted mid-FLUSH or mid-DRAIN: immediate return to reset values; `flush` drops asynchronously.

## Test plan

- Reset: assert `rst` with `rs_full`=0 → `state`=0, `credits`=32, `halt`=0, `flush`=0, `ready`=1, `err`=0.
- Fill (ROB_DEPTH=4, IPC=1): `valid_ROB`=1 for 6 cycles, `commit_count`=0 → `credits` 4,3,2,1,0; `halt`=1 from cycle 5 onward. Then `commit_count`=1 for 1 cycle → `credits`=1 next cycle and `halt` drops.
- Simultaneous events at zero credits: `credits`=0, `valid_ROB`=1, `commit_count`=1 → `halt`=1 that cycle, `credits`=1 next cycle, `halt`=0 after.
- Mispredict (DRAIN_CYCLES=2): pulse `mispredict` at cycle 10 with `credits`=5 → `flush`=1 at cycle 11; `halt`=1 in cycles 11–13; `state`=0 and `credits`=32 at cycle 14. A second pulse at cycle 12 → `flush`=1 again at cycle 13, and IDLE at cycle 16.
- Overflow: at `credits`=32, apply `commit_count`=1 → `credits` stays 32 and `err`=1. `err` holds until `rst`.
- `rs_full`=1 with `credits`=10, `valid_ROB`=1 → `halt`=1, `ready`=0, `credits` unchanged.
